// File: rtl/uart_tx_sequencer_if.sv
// Byte handshake and frame/bit-index outputs between the UART TX sequencer and its users.
// The slave side is the sequencer; the master side supplies bytes and observes the mux feed.
interface uart_tx_sequencer_if;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] frame;
  logic [3:0]  addr;
  logic        busy;
  logic        done;

  modport master (
    output din, din_valid,
    input  din_ready, frame, addr, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, frame, addr, busy, done
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Builds a 16-bit UART frame vector from an accepted byte and steps the mux bit index
// once per baud period; index 15 (always 1) is the idle-line position.
module uart_tx_sequencer #(
  parameter int unsigned DIV        = 5208,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic              clk,
  input logic              rst,
  uart_tx_sequencer_if.slave bus
);

  // Index of the final stop bit: start + 8 data + optional parity + stop bits - 1.
  localparam logic [3:0]  LAST     = 4'(8 + PARITY_EN + STOP_BITS);
  localparam logic [15:0] CNT_MAX  = 16'(DIV - 1);
  localparam logic [3:0]  IDLE_IDX = 4'd15;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;

  function automatic logic [15:0] build_frame(input logic [7:0] data);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = data;
    if (PARITY_EN != 0) f[9] = (^data) ^ (PARITY_ODD != 0);
    return f;
  endfunction

  assign accept = bus.din_valid & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '1;
      addr_q  <= IDLE_IDX;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d = build_frame(bus.din);
          addr_d  = '0;
          cnt_d   = '0;
          state_d = SEND;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (addr_q == LAST) begin
            // Ready rises together with done so a waiting byte starts after a one-cycle idle gap.
            addr_d  = IDLE_IDX;
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.din_ready = ready_q;
  assign bus.frame     = frame_q;
  assign bus.addr      = addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: four instances (8N1, 8E1, 8O1, 8N2) at DIV=4,
// with expected frames queued at drive time and checked bit period by bit period.
module tb_uart_tx_sequencer;

  localparam int DIV = 4;

  typedef struct {
    int          k;
    logic [15:0] frame;
    int          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [7:0]  din_a   [4];
  logic        valid_a [4];
  logic        ready_o [4];
  logic [15:0] frame_o [4];
  logic [3:0]  addr_o  [4];
  logic        busy_o  [4];
  logic        done_o  [4];

  always #5 clk = ~clk;

  uart_tx_sequencer_if bus0();
  uart_tx_sequencer_if bus1();
  uart_tx_sequencer_if bus2();
  uart_tx_sequencer_if bus3();

  uart_tx_sequencer #(.DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_tx_sequencer #(.DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_tx_sequencer #(.DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));
  uart_tx_sequencer #(.DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus0.din = din_a[0];  assign bus0.din_valid = valid_a[0];
  assign bus1.din = din_a[1];  assign bus1.din_valid = valid_a[1];
  assign bus2.din = din_a[2];  assign bus2.din_valid = valid_a[2];
  assign bus3.din = din_a[3];  assign bus3.din_valid = valid_a[3];

  assign ready_o[0] = bus0.din_ready; assign frame_o[0] = bus0.frame; assign addr_o[0] = bus0.addr;
  assign busy_o[0]  = bus0.busy;      assign done_o[0]  = bus0.done;
  assign ready_o[1] = bus1.din_ready; assign frame_o[1] = bus1.frame; assign addr_o[1] = bus1.addr;
  assign busy_o[1]  = bus1.busy;      assign done_o[1]  = bus1.done;
  assign ready_o[2] = bus2.din_ready; assign frame_o[2] = bus2.frame; assign addr_o[2] = bus2.addr;
  assign busy_o[2]  = bus2.busy;      assign done_o[2]  = bus2.done;
  assign ready_o[3] = bus3.din_ready; assign frame_o[3] = bus3.frame; assign addr_o[3] = bus3.addr;
  assign busy_o[3]  = bus3.busy;      assign done_o[3]  = bus3.done;

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int k);
    chk({tag, "_frame15"}, k, 16'(frame_o[k][15]), 16'h1);
    chk({tag, "_addr"},  k, 16'(addr_o[k]),  16'd15);
    chk({tag, "_ready"}, k, 16'(ready_o[k]), 16'd1);
    chk({tag, "_busy"},  k, 16'(busy_o[k]),  16'd0);
    chk({tag, "_done"},  k, 16'(done_o[k]),  16'd0);
  endtask

  // Called one step after a posedge while the DUT is idle; returns one step after the accept edge.
  task automatic drive(input int k, input logic [7:0] b, input logic [15:0] fexp,
                       input int last, input bit hold);
    chk("ready_pre", k, 16'(ready_o[k]), 16'd1);
    din_a[k]   = b;
    valid_a[k] = 1'b1;
    sb.push_back('{k, fexp, last});
    tick;
    if (!hold) valid_a[k] = 1'b0;
  endtask

  // Starts at the first sample after accept and ends at the done-cycle sample.
  task automatic check_frame(input bit pulse);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    for (int idx = 0; idx <= e.last; idx++) begin
      for (int c = 0; c < DIV; c++) begin
        chk("frame", e.k, frame_o[e.k], e.frame);
        chk("addr",  e.k, 16'(addr_o[e.k]), 16'(idx));
        chk("busy",  e.k, 16'(busy_o[e.k]), 16'd1);
        chk("ready", e.k, 16'(ready_o[e.k]), 16'd0);
        chk("done",  e.k, 16'(done_o[e.k]), 16'd0);
        if (pulse && idx == 2 && c == 1) begin
          din_a[e.k]   = 8'hC3;
          valid_a[e.k] = 1'b1;
        end else if (pulse && idx == 2 && c == 2) begin
          valid_a[e.k] = 1'b0;
        end
        tick;
      end
    end
    chk("end_done",  e.k, 16'(done_o[e.k]),  16'd1);
    chk("end_addr",  e.k, 16'(addr_o[e.k]),  16'd15);
    chk("end_ready", e.k, 16'(ready_o[e.k]), 16'd1);
    chk("end_busy",  e.k, 16'(busy_o[e.k]),  16'd0);
    chk("end_frame", e.k, frame_o[e.k], e.frame);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      din_a[i]   = 8'h00;
      valid_a[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_frame", i, frame_o[i], 16'hFFFF);
      chk_idle("rst", i);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;

    // 8N1 single byte
    drive(0, 8'hA5, 16'hFF4A, 9, 1'b0);
    check_frame(1'b0);
    tick;
    chk_idle("after_8n1", 0);

    // Parity and two-stop-bit variants
    drive(1, 8'hA5, 16'hFD4A, 10, 1'b0);
    check_frame(1'b0);
    drive(2, 8'hA5, 16'hFF4A, 10, 1'b0);
    check_frame(1'b0);
    drive(3, 8'h00, 16'hFE00, 10, 1'b0);
    check_frame(1'b0);
    tick;
    chk_idle("after_8n2", 3);

    // Back-to-back with din_valid held; din changes during SEND
    drive(0, 8'h55, 16'hFEAA, 9, 1'b1);
    din_a[0] = 8'h0F;
    sb.push_back('{0, 16'hFE1E, 9});
    check_frame(1'b0);
    tick;
    valid_a[0] = 1'b0;
    check_frame(1'b0);
    tick;
    chk_idle("after_b2b", 0);

    // Handshake hold: valid pulsed mid-frame is ignored
    drive(0, 8'h3C, 16'hFE78, 9, 1'b0);
    check_frame(1'b1);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk_idle("no_extra", 0);
      chk("no_extra_frame", 0, frame_o[0], 16'hFE78);
    end

    // Reset mid-frame
    din_a[0]   = 8'hA5;
    valid_a[0] = 1'b1;
    tick;
    valid_a[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("pre_rst_busy", 0, 16'(busy_o[0]), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_frame", 0, frame_o[0], 16'hFFFF);
    chk_idle("async_rst", 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_hold_done", 0, 16'(done_o[0]), 16'd0);
      chk("rst_hold_busy", 0, 16'(busy_o[0]), 16'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    din_a[0]   = 8'hA5;
    valid_a[0] = 1'b1;
    sb.push_back('{0, 16'hFF4A, 9});
    tick;
    valid_a[0] = 1'b0;
    check_frame(1'b0);
    tick;
    chk_idle("final", 0);
    chk("sb_drained", 0, 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
